// File: rtl/key_expander.sv
// AES-128 round-key generator: emits rk0..rk10 one at a time over a valid/ready port.
// The next round key is derived from the key currently on the port, so no schedule storage is needed.
module key_expander (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] round_key,
  output logic [3:0]   rk_index,
  output logic         busy,
  output logic         done
);

  // Handshake: a round key transfers on any cycle where rk_valid && rk_ready;
  // while rk_valid is high and rk_ready is low, round_key/rk_index hold steady.

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constant used when stepping from round idx to round idx+1.
  function automatic logic [7:0] rcon_for(input logic [3:0] idx);
    case (idx)
      4'd0:    rcon_for = 8'h01;
      4'd1:    rcon_for = 8'h02;
      4'd2:    rcon_for = 8'h04;
      4'd3:    rcon_for = 8'h08;
      4'd4:    rcon_for = 8'h10;
      4'd5:    rcon_for = 8'h20;
      4'd6:    rcon_for = 8'h40;
      4'd7:    rcon_for = 8'h80;
      4'd8:    rcon_for = 8'h1b;
      4'd9:    rcon_for = 8'h36;
      default: rcon_for = 8'h00;
    endcase
  endfunction

  state_t       state, state_n;
  logic         rk_valid_n, busy_n, done_n;
  logic [127:0] round_key_n, next_key;
  logic [3:0]   rk_index_n;
  logic [31:0]  rot_w3, temp, w0n, w1n, w2n, w3n;

  always_comb begin
    rot_w3 = {round_key[23:0], round_key[31:24]};
    temp   = {SBOX[rot_w3[31:24]] ^ rcon_for(rk_index), SBOX[rot_w3[23:16]],
              SBOX[rot_w3[15:8]], SBOX[rot_w3[7:0]]};
    w0n    = round_key[127:96] ^ temp;
    w1n    = round_key[95:64]  ^ w0n;
    w2n    = round_key[63:32]  ^ w1n;
    w3n    = round_key[31:0]   ^ w2n;
    next_key = {w0n, w1n, w2n, w3n};
  end

  always_comb begin
    state_n     = state;
    rk_valid_n  = rk_valid;
    busy_n      = busy;
    round_key_n = round_key;
    rk_index_n  = rk_index;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n     = EMIT;
          round_key_n = key_in;
          rk_index_n  = 4'd0;
          rk_valid_n  = 1'b1;
          busy_n      = 1'b1;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (rk_index == 4'd10) begin
            state_n    = IDLE;
            rk_valid_n = 1'b0;
            busy_n     = 1'b0;
            done_n     = 1'b1;
          end else begin
            round_key_n = next_key;
            rk_index_n  = rk_index + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rk_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rk_index  <= 4'd0;
      round_key <= 128'd0;
    end else begin
      state     <= state_n;
      rk_valid  <= rk_valid_n;
      busy      <= busy_n;
      done      <= done_n;
      rk_index  <= rk_index_n;
      round_key <= round_key_n;
    end
  end

endmodule

// File: tb/tb_key_expander.sv
// Bench for key_expander: the reference derives the S-box from GF(2^8) arithmetic and
// expands keys word-by-word, then tracks which key the port should present each cycle.
module tb_key_expander;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] ALT_KEY   = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst, start, rk_ready;
  logic [127:0] key_in;
  logic         rk_valid, busy, done;
  logic [127:0] round_key;
  logic [3:0]   rk_index;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;
  bit chk_en   = 1'b0;

  key_expander dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .rk_ready(rk_ready),
    .rk_valid(rk_valid), .round_key(round_key), .rk_index(rk_index),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [7:0]   ref_sbox [256];
  logic [127:0] mdl_keys [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  task automatic build_sbox();
    for (int b = 0; b < 256; b++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] bb = 8'(b);
      for (int c = 1; c < 256; c++)
        if (b != 0 && gmul(bb, 8'(c)) == 8'h01) inv = 8'(c);
      ref_sbox[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {ref_sbox[t[31:24]] ^ rc, ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mdl_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Which key the port should be showing, advanced by the observed handshake.
  bit           mdl_active = 1'b0;
  bit           mdl_done   = 1'b0;
  int           mdl_idx    = 0;
  logic [127:0] mdl_shown  = '0;

  always @(posedge clk) begin
    if (rst) begin
      mdl_active = 1'b0; mdl_done = 1'b0; mdl_idx = 0; mdl_shown = '0;
    end else begin
      mdl_done = 1'b0;
      if (!mdl_active) begin
        if (start) begin
          build_model(key_in);
          mdl_active = 1'b1; mdl_idx = 0; mdl_shown = mdl_keys[0];
        end
      end else if (rk_ready) begin
        if (mdl_idx == 10) begin
          mdl_active = 1'b0; mdl_done = 1'b1;
        end else begin
          mdl_idx++;
          mdl_shown = mdl_keys[mdl_idx];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rk_valid", 128'(rk_valid), 128'(mdl_active));
      check("busy", 128'(busy), 128'(mdl_active));
      check("done", 128'(done), 128'(mdl_done));
      check("rk_index", 128'(rk_index), 128'(mdl_idx));
      check("round_key", round_key, mdl_shown);
      if (done === 1'b1) done_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [127:0] key);
    start = 1'b1; key_in = key;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget, input bit random_ready);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      if (random_ready) rk_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    check("done_within_budget", 128'(done), 128'd1);
    rk_ready = 1'b1;
  endtask

  task automatic run_to_index(input logic [3:0] idx, input int budget);
    int n = 0;
    while (rk_index !== idx && n < budget) begin
      step();
      n++;
    end
    check("reach_index", 128'(rk_index), 128'(idx));
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; rk_ready = 1'b1; key_in = '0;
    build_sbox();
    build_model(FIPS_KEY);
    check("model_fips_rk1", mdl_keys[1], FIPS_RK1);
    check("model_fips_rk10", mdl_keys[10], FIPS_RK10);
    build_model('0);
    check("model_zero_rk1", mdl_keys[1], ZERO_RK1);
    check("model_zero_rk10", mdl_keys[10], ZERO_RK10);

    // Reset, with start asserted to show reset wins.
    start = 1'b1; key_in = FIPS_KEY;
    step(); step();
    start = 1'b0;
    check("reset_valid", 128'(rk_valid), 128'd0);
    check("reset_round_key", round_key, 128'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    step(); step();
    check("idle_busy", 128'(busy), 128'd0);

    // FIPS-197 key, consumer always ready: fixed-latency literal checks.
    d0 = done_seen;
    pulse_start(FIPS_KEY);
    check("fips_rk0", round_key, FIPS_KEY);
    check("fips_idx0", 128'(rk_index), 128'd0);
    step();
    check("fips_rk1", round_key, FIPS_RK1);
    repeat (9) step();
    check("fips_rk10", round_key, FIPS_RK10);
    check("fips_idx10", 128'(rk_index), 128'd10);
    step();
    check("fips_done_pulse", 128'(done), 128'd1);
    check("fips_valid_low", 128'(rk_valid), 128'd0);
    check("idle_keeps_key", round_key, FIPS_RK10);
    step();
    check("fips_done_cleared", 128'(done), 128'd0);
    check("fips_done_once", 128'(done_seen - d0), 128'd1);

    // All-zero key.
    pulse_start('0);
    step();
    check("zero_rk1", round_key, ZERO_RK1);
    run_to_done(40, 1'b0);
    step();

    // Random backpressure.
    d0 = done_seen;
    pulse_start(FIPS_KEY);
    run_to_done(400, 1'b1);
    step();
    check("random_done_once", 128'(done_seen - d0), 128'd1);

    // Start with another key mid-expansion is ignored.
    pulse_start(FIPS_KEY);
    run_to_index(4'd4, 20);
    pulse_start(ALT_KEY);
    key_in = ALT_KEY;
    run_to_done(40, 1'b0);
    check("ignore_start_rk10", round_key, FIPS_RK10);
    step();

    // Reset at round 6 abandons the expansion.
    d0 = done_seen;
    pulse_start(FIPS_KEY);
    run_to_index(4'd6, 20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_valid", 128'(rk_valid), 128'd0);
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_round_key", round_key, 128'd0);
    repeat (3) step();
    check("abort_no_done", 128'(done_seen - d0), 128'd0);
    pulse_start(FIPS_KEY);
    step();
    check("restart_rk1", round_key, FIPS_RK1);
    run_to_done(40, 1'b0);

    // Start accepted in the done cycle.
    start = 1'b1; key_in = ALT_KEY;
    step();
    start = 1'b0;
    check("b2b_valid", 128'(rk_valid), 128'd1);
    check("b2b_rk0", round_key, ALT_KEY);
    check("b2b_idx0", 128'(rk_index), 128'd0);
    run_to_done(40, 1'b0);
    repeat (2) step();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
